// File: rtl/time_7seg_scanner.sv
// Multiplexed 6-digit HH.MM.SS 7-segment scanner with ghost blanking,
// frame-coherent time snapshot, blinking colon dots and a night indicator.
module time_7seg_scanner #(
   parameter int unsigned SCAN_DIV   = 100,
   parameter int unsigned BLANK_CYC  = 2,
   parameter int unsigned BLANK_LEAD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] hour,
   input  logic [7:0] min,
   input  logic [7:0] sec,
   input  logic       d_or_n,
   output logic [7:0] seg_data,
   output logic [5:0] seg_com
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          colon_q, colon_d;
   logic [3:0]    sec_prev_q;
   logic [7:0]    hour_sh_q, min_sh_q, sec_sh_q;
   logic          dn_sh_q;
   logic          load_pend_q;
   logic [7:0]    seg_data_q, seg_data_d;
   logic [5:0]    seg_com_q, seg_com_d;

   logic          slot_end, frame_end, blank;
   logic [3:0]    nib;
   logic [7:0]    code;
   logic          dp;

   always_comb begin
      slot_end  = (32'(cnt_q) == SCAN_DIV - 1);
      frame_end = slot_end && (idx_q == 3'd5);
      blank     = (32'(cnt_q) < BLANK_CYC);
      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (slot_end) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      colon_d   = (sec[3:0] != sec_prev_q) ? ~colon_q : colon_q;

      case (idx_q)
         3'd0:    nib = hour_sh_q[7:4];
         3'd1:    nib = hour_sh_q[3:0];
         3'd2:    nib = min_sh_q[7:4];
         3'd3:    nib = min_sh_q[3:0];
         3'd4:    nib = sec_sh_q[7:4];
         default: nib = sec_sh_q[3:0];
      endcase

      case (nib)
         4'd0:    code = 8'hFC;
         4'd1:    code = 8'h60;
         4'd2:    code = 8'hDA;
         4'd3:    code = 8'hF2;
         4'd4:    code = 8'h66;
         4'd5:    code = 8'hB6;
         4'd6:    code = 8'hBE;
         4'd7:    code = 8'hE0;
         4'd8:    code = 8'hFE;
         4'd9:    code = 8'hF6;
         default: code = 8'h00;
      endcase

      case (idx_q)
         3'd1, 3'd3: dp = colon_q;
         3'd5:       dp = dn_sh_q;
         default:    dp = 1'b0;
      endcase

      seg_com_d  = '1;
      seg_data_d = '0;
      if (!blank) begin
         seg_com_d[idx_q] = 1'b0;
         seg_data_d       = {code[7:1], dp};
         // Leading-zero suppression keeps the digit selected so scan timing is unchanged.
         if (BLANK_LEAD != 0 && idx_q == 3'd0 && hour_sh_q[7:4] == 4'd0)
            seg_data_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         colon_q     <= 1'b0;
         sec_prev_q  <= '0;
         hour_sh_q   <= '0;
         min_sh_q    <= '0;
         sec_sh_q    <= '0;
         dn_sh_q     <= 1'b0;
         load_pend_q <= 1'b1;
         seg_data_q  <= '0;
         seg_com_q   <= '1;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         colon_q    <= colon_d;
         sec_prev_q <= sec[3:0];
         seg_data_q <= seg_data_d;
         seg_com_q  <= seg_com_d;
         if (load_pend_q || frame_end) begin
            hour_sh_q   <= hour;
            min_sh_q    <= min;
            sec_sh_q    <= sec;
            dn_sh_q     <= d_or_n;
            load_pend_q <= 1'b0;
         end
      end
   end

   assign seg_data = seg_data_q;
   assign seg_com  = seg_com_q;

endmodule

// File: tb/tb_time_7seg_scanner.sv
// Directed bench for time_7seg_scanner: frame-position model checked every cycle
// on two instances (leading blank on/off) plus hand-computed literal expectations.
module tb_time_7seg_scanner;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int FR = 6 * SD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] hour, min, sec;
   logic       dn;
   logic [7:0] sd1, sd0;
   logic [5:0] sc1, sc0;

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   time_7seg_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LEAD(1)) dut1 (
      .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec), .d_or_n(dn),
      .seg_data(sd1), .seg_com(sc1));

   time_7seg_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LEAD(0)) dut0 (
      .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec), .d_or_n(dn),
      .seg_data(sd0), .seg_com(sc0));

   // Model: scan position k since reset release, snapshot per frame, colon from live sec.
   int         mk;
   logic [24:0] msh;
   bit         mpend, mcolon;
   logic [3:0] mprev;
   logic [7:0] exd1, exd0;
   logic [5:0] exc;
   logic [7:0] segtab [16];

   task automatic model_reset();
      mk = 0; msh = '0; mpend = 1'b1; mcolon = 1'b0; mprev = '0;
      exc = 6'h3F; exd1 = 8'h00; exd0 = 8'h00;
   endtask

   initial begin
      int pos, idx, c;
      logic [3:0] nib;
      logic dp;
      segtab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else begin
            pos = mk % FR; idx = pos / SD; c = pos % SD;
            if (c < BC) begin
               exc = 6'h3F; exd1 = 8'h00; exd0 = 8'h00;
            end else begin
               exc = 6'h3F;
               exc[idx] = 1'b0;
               nib = msh[24 - 4*idx -: 4];
               dp = (idx == 1 || idx == 3) ? mcolon : (idx == 5) ? msh[0] : 1'b0;
               exd0 = {segtab[nib][7:1], dp};
               exd1 = (idx == 0 && nib == 4'd0) ? 8'h00 : exd0;
            end
            if (mpend || pos == FR - 1) begin
               msh = {hour, min, sec, dn};
               mpend = 1'b0;
            end
            if (sec[3:0] != mprev) mcolon = ~mcolon;
            mprev = sec[3:0];
            mk++;
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("com_lead1",  {2'b00, sc1}, {2'b00, exc});
            chk("data_lead1", sd1, exd1);
            chk("com_lead0",  {2'b00, sc0}, {2'b00, exc});
            chk("data_lead0", sd0, exd0);
            chk("onecold", ($countones(~sc1) <= 1) ? 8'd1 : 8'd0, 8'd1);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [5:0] c1, input logic [7:0] d1,
                      input logic [7:0] d0);
      chk({nm, "_com1"},  {2'b00, sc1}, {2'b00, c1});
      chk({nm, "_data1"}, sd1, d1);
      chk({nm, "_com0"},  {2'b00, sc0}, {2'b00, c1});
      chk({nm, "_data0"}, sd0, d0);
   endtask

   initial begin
      bit found;
      hour = 8'h12; min = 8'h34; sec = 8'h56; dn = 1'b0;
      #1 rst = 1'b0;
      #1 armed = 1'b1;
      cyc(2);
      lit("reset", 6'h3F, 8'h00, 8'h00);
      #2 rst = 1'b1;

      cyc(1); lit("k0_blank", 6'h3F, 8'h00, 8'h00);
      cyc(1); lit("k1_d0", 6'h3E, 8'h60, 8'h60);
      cyc(3); lit("k4_blank", 6'h3F, 8'h00, 8'h00);
      cyc(1); lit("k5_d1", 6'h3D, 8'hDB, 8'hDB);
      cyc(4); lit("k9_d2", 6'h3B, 8'hF2, 8'hF2);

      // mid-frame minute change stays hidden until the next frame
      #2 min = 8'h35;
      cyc(4); lit("k13_d3_old", 6'h37, 8'h67, 8'h67);
      cyc(24); lit("k37_d3_new", 6'h37, 8'hB7, 8'hB7);

      #2 sec = 8'h57; dn = 1'b1;
      cyc(8);  lit("k45_d5_old", 6'h1F, 8'hBE, 8'hBE);
      cyc(8);  lit("k53_d1_colon", 6'h3D, 8'hDA, 8'hDA);
      cyc(16); lit("k69_d5_night", 6'h1F, 8'hE1, 8'hE1);

      #2 hour = 8'h09;
      cyc(4); lit("k73_lead", 6'h3E, 8'h00, 8'hFC);
      #2 hour = 8'hA3;
      cyc(24); lit("k97_nibA", 6'h3E, 8'h00, 8'h00);

      #2 hour = 8'h12;
      found = 1'b0;
      for (int i = 0; i < 2 * FR && !found; i++) begin
         cyc(1);
         if (mk % FR == 14) found = 1'b1;
      end
      chk("reach_idx3_cnt2", found ? 8'd1 : 8'd0, 8'd1);
      #2 rst = 1'b0; hour = 8'h21;
      #1 lit("midscan_reset", 6'h3F, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      cyc(1); lit("rel_blank", 6'h3F, 8'h00, 8'h00);
      cyc(1); lit("rel_d0_fresh", 6'h3E, 8'hDA, 8'hDA);

      // free-running seconds count; model follows every cycle
      for (int i = 0; i < 12; i++) begin
         cyc(7);
         #2;
         if (sec[3:0] == 4'd9) sec = {sec[7:4] + 4'd1, 4'd0};
         else sec = {sec[7:4], sec[3:0] + 4'd1};
         dn = ~dn;
         min = (i % 3 == 0) ? 8'h00 : 8'h59;
      end
      cyc(2 * FR);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
